// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the data-memory stage: icode constants,
// FSM state encoding and the icode-to-access-kind classifier.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } dmemState_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE
  } accKind_t;

  function automatic accKind_t classifyIcode(input logic [3:0] icode);
    accKind_t kind;
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: kind = ACC_WRITE;
      I_MRMOVQ, I_RET, I_POPQ:   kind = ACC_READ;
      default:                   kind = ACC_NONE;
    endcase
    return kind;
  endfunction

  // ret and popq read through the stack pointer carried on valA.
  function automatic logic addrFromValA(input logic [3:0] icode);
    return (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed little-endian RAM: synchronous word write, combinational
// word read. Bytes falling past the end of the array read as zero.
module y86_dmem_array #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH_BYTES):0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [$clog2(DEPTH_BYTES):0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH_BYTES) + 1;
  localparam int IW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] wIdx [NB];
  logic [AW-1:0] rIdx [NB];

  for (genvar b = 0; b < NB; b++) begin : gByte
    assign wIdx[b] = waddr + AW'(b);
    assign rIdx[b] = raddr + AW'(b);
    assign rdata[8*b +: 8] = (rIdx[b] < AW'(DEPTH_BYTES)) ? mem[rIdx[b][IW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wIdx[b] < AW'(DEPTH_BYTES)) begin
          mem[wIdx[b][IW-1:0]] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/y86_dmem_stage.sv
// Y86-64 SEQ data-memory stage with start/done handshake and wait states.
// Define DMEM_ALIGN_CHECK_EN to also flag unaligned accesses as errors.
module y86_dmem_stage
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic [DATA_W-1:0] valM,
  output logic              busy,
  output logic              done,
  output logic              dmem_error
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH_BYTES) + 1;
  localparam logic [DATA_W-1:0] MAX_ADDR  = DATA_W'(DEPTH_BYTES - NB);
  localparam logic [3:0]        WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dmemState_t        state, stateNext;
  logic [3:0]        waitCnt, waitCntNext;
  accKind_t          reqKind, inKind, curKind;
  logic [DATA_W-1:0] reqAddr, inAddr, curAddr;
  logic [DATA_W-1:0] reqData, inData, curData;
  logic [DATA_W-1:0] rdData;
  logic              latchReq, enterDone;
  logic              rangeErr, alignErr, accErr, memWe;

  assign inKind = classifyIcode(icode);
  assign inAddr = addrFromValA(icode) ? valA : valE;
  assign inData = (icode == I_CALL) ? valP : valA;

  // With zero wait states DONE is entered on the accepting edge itself,
  // so the live inputs stand in for the not-yet-latched request.
  always_comb begin
    curKind = reqKind;
    curAddr = reqAddr;
    curData = reqData;
    if (state == ST_IDLE) begin
      curKind = inKind;
      curAddr = inAddr;
      curData = inData;
    end
  end

  assign rangeErr = curAddr > MAX_ADDR;
`ifdef DMEM_ALIGN_CHECK_EN
  assign alignErr = (curAddr % DATA_W'(NB)) != '0;
`else
  assign alignErr = 1'b0;
`endif
  assign accErr = (curKind != ACC_NONE) && (rangeErr || alignErr);

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    latchReq    = 1'b0;
    enterDone   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latchReq = 1'b1;
          if ((curKind != ACC_NONE) && (WAIT_CYCLES > 0)) begin
            stateNext   = ST_WAIT;
            waitCntNext = WAIT_LOAD;
          end else begin
            stateNext = ST_DONE;
            enterDone = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (waitCnt == 4'd0) begin
          stateNext = ST_DONE;
          enterDone = 1'b1;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Reset blocks the commit so an aborted store never reaches the array.
  assign memWe = enterDone && (curKind == ACC_WRITE) && !accErr && !rst;

  y86_dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) uArray (
    .clk   (clk),
    .we    (memWe),
    .waddr (curAddr[AW-1:0]),
    .wdata (curData),
    .raddr (curAddr[AW-1:0]),
    .rdata (rdData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      waitCnt    <= 4'd0;
      reqKind    <= ACC_NONE;
      reqAddr    <= '0;
      reqData    <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (latchReq) begin
        reqKind <= inKind;
        reqAddr <= inAddr;
        reqData <= inData;
      end
      if (enterDone) begin
        dmem_error <= accErr;
        if (accErr) begin
          valM <= '0;
        end else if (curKind == ACC_READ) begin
          valM <= rdData;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
